config_chain_register: RTL and testbench

Parametrised, double-buffered configuration register for kfpga tiles. A `LANES`-bit-wide serial shift chain accepts the bitstream, counts beats, and drives the previous tile's bits onward through `data_shift_out`. A shadow register, updated only on an explicit `commit`, holds the live configuration. The tile fabric never sees a half-shifted bitstream. Instances are daisy-chained: one tile's `data_shift_out` feeds the next tile's `data_in`.

---
 rtl/config_chain_if.sv | 34 +++
 rtl/config_chain_register.sv | 78 +++++++
 tb/tb_config_chain_register.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/config_chain_if.sv
// Bitstream/config bus of a config_chain_register tile.
// The readback signal exists only when CONFIG_READBACK_EN is defined.
interface config_chain_if #(
    parameter int WIDTH = 36,
    parameter int LANES = 1
);
    logic             enable;
    logic [LANES-1:0] data_in;
    logic [LANES-1:0] data_shift_out;
    logic             commit;
`ifdef CONFIG_READBACK_EN
    logic             readback;
`endif
    logic [WIDTH-1:0] data_out;
    logic             loaded;
    logic             config_valid;
    logic             error;

    modport master (
        output enable, data_in, commit,
`ifdef CONFIG_READBACK_EN
        output readback,
`endif
        input  data_shift_out, data_out, loaded, config_valid, error
    );

    modport slave (
        input  enable, data_in, commit,
`ifdef CONFIG_READBACK_EN
        input  readback,
`endif
        output data_shift_out, data_out, loaded, config_valid, error
    );
endinterface

// File: rtl/config_chain_register.sv
// Double-buffered tile configuration register: serial shift chain plus commit-loaded shadow.
// Optional CONFIG_READBACK_EN reloads the shift chain from the shadow for bitstream verification.
module config_chain_register #(
    parameter int WIDTH = 36,
    parameter int LANES = 1
) (
    input logic           clock,
    input logic           reset,
    config_chain_if.slave bus
);
    localparam int BEATS = WIDTH / LANES;
    localparam int CW    = $clog2(BEATS + 1);
    localparam logic [CW-1:0] BEATS_C = CW'(BEATS);

    logic [WIDTH-1:0] sreg;
    logic [WIDTH-1:0] sreg_shift;
    logic [WIDTH-1:0] shadow;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_nxt;
    logic             loaded_q;
    logic             valid_q;
    logic             error_q;
    logic             accept;

    // A single-beat chain has no retained bits; the beat replaces the whole register.
    generate
        if (BEATS == 1) begin : g_one_beat
            assign sreg_shift = bus.data_in;
        end else begin : g_multi_beat
            assign sreg_shift = {sreg[WIDTH-LANES-1:0], bus.data_in};
        end
    endgenerate

    assign accept = bus.commit & loaded_q;

    // Accepted commit restarts the count before this cycle's beat is added.
    always_comb begin
        cnt_nxt = accept ? '0 : cnt;
        if (bus.enable && cnt_nxt != BEATS_C)
            cnt_nxt = cnt_nxt + CW'(1);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sreg     <= '0;
            shadow   <= '0;
            cnt      <= '0;
            loaded_q <= 1'b0;
            valid_q  <= 1'b0;
            error_q  <= 1'b0;
        end
`ifdef CONFIG_READBACK_EN
        else if (bus.readback) begin
            sreg     <= shadow;
            cnt      <= BEATS_C;
            loaded_q <= 1'b1;
        end
`endif
        else begin
            if (bus.enable)
                sreg <= sreg_shift;
            cnt      <= cnt_nxt;
            loaded_q <= (cnt_nxt == BEATS_C);
            if (accept) begin
                shadow  <= sreg;
                valid_q <= 1'b1;
            end
            if (bus.commit && !loaded_q)
                error_q <= 1'b1;
        end
    end

    assign bus.data_shift_out = sreg[WIDTH-1 -: LANES];
    assign bus.data_out       = shadow;
    assign bus.loaded         = loaded_q;
    assign bus.config_valid   = valid_q;
    assign bus.error          = error_q;
endmodule

// File: tb/tb_config_chain_register.sv
// Two chained tiles (36 bits, 4 lanes) checked against a nibble-history model.
module tb_config_chain_register;
    localparam int W = 36;
    localparam int L = 4;
    localparam int B = W / L;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    config_chain_if #(.WIDTH(W), .LANES(L)) ifa (), ifb ();

    assign ifb.enable  = ifa.enable;
    assign ifb.data_in = ifa.data_shift_out;
`ifdef CONFIG_READBACK_EN
    assign ifb.readback = ifa.readback;
`endif

    config_chain_register #(.WIDTH(W), .LANES(L)) u_a (.clock(clock), .reset(reset), .bus(ifa.slave));
    config_chain_register #(.WIDTH(W), .LANES(L)) u_b (.clock(clock), .reset(reset), .bus(ifb.slave));

    // Model: h[0] is the newest nibble entering tile A; tile t holds h[9t .. 9t+8].
    logic [3:0]   h [2*B];
    int           cnt [2];
    logic [W-1:0] dout [2];
    bit           cv [2];
    bit           err [2];
    int           n_tests = 0;
    int           n_fail  = 0;

    function automatic logic [W-1:0] msreg(int t);
        logic [W-1:0] r;
        for (int i = 0; i < B; i++) r[4*i +: 4] = h[B*t + i];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("a_shift",  64'(ifa.data_shift_out), 64'(h[B-1]));
        chk("b_shift",  64'(ifb.data_shift_out), 64'(h[2*B-1]));
        chk("a_dout",   64'(ifa.data_out),       64'(dout[0]));
        chk("b_dout",   64'(ifb.data_out),       64'(dout[1]));
        chk("a_loaded", 64'(ifa.loaded),         64'(cnt[0] == B));
        chk("b_loaded", 64'(ifb.loaded),         64'(cnt[1] == B));
        chk("a_valid",  64'(ifa.config_valid),   64'(cv[0]));
        chk("b_valid",  64'(ifb.config_valid),   64'(cv[1]));
        chk("a_error",  64'(ifa.error),          64'(err[0]));
        chk("b_error",  64'(ifb.error),          64'(err[1]));
    endtask

    task automatic step(input logic en, input logic [3:0] din, input logic ca, input logic cb,
                        input logic rb, input logic rst);
        logic [W-1:0] pre [2];
        ifa.enable  = en;
        ifa.data_in = din;
        ifa.commit  = ca;
        ifb.commit  = cb;
`ifdef CONFIG_READBACK_EN
        ifa.readback = rb;
`endif
        reset = rst;
        @(posedge clock);
        #1;
        if (rst) begin
            for (int i = 0; i < 2*B; i++) h[i] = '0;
            for (int t = 0; t < 2; t++) begin
                cnt[t] = 0; dout[t] = '0; cv[t] = 0; err[t] = 0;
            end
        end else if (rb) begin
            for (int i = 0; i < B; i++) begin
                h[i]     = dout[0][4*i +: 4];
                h[B + i] = dout[1][4*i +: 4];
            end
            cnt[0] = B;
            cnt[1] = B;
        end else begin
            pre[0] = msreg(0);
            pre[1] = msreg(1);
            for (int t = 0; t < 2; t++) begin
                if (t == 0 ? ca : cb) begin
                    if (cnt[t] == B) begin
                        dout[t] = pre[t]; cv[t] = 1; cnt[t] = 0;
                    end else begin
                        err[t] = 1;
                    end
                end
                if (en) cnt[t] = (cnt[t] < B) ? cnt[t] + 1 : B;
            end
            if (en) begin
                for (int i = 2*B-1; i > 0; i--) h[i] = h[i-1];
                h[0] = din;
            end
        end
        check_all();
    endtask

    initial begin
        for (int i = 0; i < 2*B; i++) h[i] = '0;
        step(0, 0, 0, 0, 0, 1);
        chk("rst_dout",  64'(ifa.data_out), 64'd0);
        chk("rst_valid", 64'(ifa.config_valid), 64'd0);

        // Nine beats 0x1..0x9 then commit
        for (int i = 1; i <= B; i++) step(1, 4'(i), 0, 0, 0, 0);
        chk("t1_loaded_pre", 64'(ifa.loaded), 64'd1);
        step(0, 0, 1, 0, 0, 0);
        chk("t1_dout",   64'(ifa.data_out), 64'h123456789);
        chk("t1_loaded", 64'(ifa.loaded), 64'd0);
        chk("t1_valid",  64'(ifa.config_valid), 64'd1);
        chk("t1_error",  64'(ifa.error), 64'd0);

        // Premature commit is rejected and error sticks
        for (int i = 0; i < 5; i++) step(1, 4'($urandom), 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0);
        chk("t2_error", 64'(ifa.error), 64'd1);
        chk("t2_dout",  64'(ifa.data_out), 64'h123456789);
        for (int i = 0; i < 4; i++) step(1, 4'($urandom), 0, 0, 0, 0);
        chk("t2_error_sticky", 64'(ifa.error), 64'd1);

        // Commit together with a beat: pre-shift capture, count restarts at 1
        step(1, 4'hA, 1, 0, 0, 0);
        chk("t3_loaded", 64'(ifa.loaded), 64'd0);
        for (int i = 0; i < B-1; i++) step(1, 0, 0, 0, 0, 0);
        chk("t3_lsb_out", 64'(ifa.data_shift_out), 64'hA);

        // Two-tile chain: 18 beats, commit both
        step(0, 0, 0, 0, 0, 1);
        for (int i = 1; i <= 2*B; i++) step(1, 4'(i), 0, 0, 0, 0);
        step(0, 0, 1, 1, 0, 0);
        chk("t4_b_dout", 64'(ifb.data_out), 64'h123456789);
        chk("t4_a_dout", 64'(ifa.data_out), 64'hABCDEF012);

        // Reset mid-stream, then a fresh load
        for (int i = 1; i <= 4; i++) step(1, 4'(i), 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1);
        chk("t5_dout",  64'(ifa.data_out), 64'd0);
        chk("t5_shift", 64'(ifa.data_shift_out), 64'd0);
        chk("t5_valid", 64'(ifa.config_valid), 64'd0);
        chk("t5_error", 64'(ifa.error), 64'd0);
        for (int i = 1; i <= B; i++) step(1, 4'(i), 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0);
        chk("t5_reload", 64'(ifa.data_out), 64'h123456789);

`ifdef CONFIG_READBACK_EN
        step(0, 0, 0, 0, 1, 0);
        chk("rb_first", 64'(ifa.data_shift_out), 64'd1);
        for (int j = 2; j <= B; j++) begin
            step(1, 0, 0, 0, 0, 0);
            chk("rb_seq", 64'(ifa.data_shift_out), 64'(j));
        end
        chk("rb_dout", 64'(ifa.data_out), 64'h123456789);
        for (int i = 0; i < 3; i++) step(1, 4'($urandom), 0, 0, 0, 0);
        step(0, 0, 1, 0, 1, 0);
        chk("rb_commit_err",  64'(ifa.error), 64'd0);
        chk("rb_commit_dout", 64'(ifa.data_out), 64'h123456789);
`endif

        // Randomized traffic against the model
        for (int n = 0; n < 2000; n++) begin
            logic rb;
`ifdef CONFIG_READBACK_EN
            rb = ($urandom_range(0, 39) == 0);
`else
            rb = 1'b0;
`endif
            step($urandom_range(0, 3) != 0, 4'($urandom),
                 $urandom_range(0, 12) == 0, $urandom_range(0, 12) == 0,
                 rb, $urandom_range(0, 249) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
